// File: rtl/vga_pkg.sv
// Shared VGA timing presets, raster control bundle and axis-bound helper.
package vga_pkg;

   localparam int VGA_COLOR_W = 4;

   // 640x480@60, 25.175 MHz pixel clock, negative syncs
   localparam int VGA640_H_VISIBLE = 640;
   localparam int VGA640_H_FRONT   = 16;
   localparam int VGA640_H_SYNC    = 96;
   localparam int VGA640_H_BACK    = 48;
   localparam int VGA640_V_VISIBLE = 480;
   localparam int VGA640_V_FRONT   = 10;
   localparam int VGA640_V_SYNC    = 2;
   localparam int VGA640_V_BACK    = 33;
   localparam bit VGA640_SYNC_POS  = 1'b0;

   // 800x600@60, 40 MHz pixel clock, positive syncs
   localparam int VGA800_H_VISIBLE = 800;
   localparam int VGA800_H_FRONT   = 40;
   localparam int VGA800_H_SYNC    = 128;
   localparam int VGA800_H_BACK    = 88;
   localparam int VGA800_V_VISIBLE = 600;
   localparam int VGA800_V_FRONT   = 1;
   localparam int VGA800_V_SYNC    = 4;
   localparam int VGA800_V_BACK    = 23;
   localparam bit VGA800_SYNC_POS  = 1'b1;

   typedef struct packed {
      int unsigned total;
      int unsigned sync_first;
      int unsigned sync_last;
   } axis_bounds_t;

   // Active-high raster flags; sync polarity is applied only at the output registers.
   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } raster_ctl_t;

   function automatic axis_bounds_t axis_bounds(input int unsigned visible,
                                                input int unsigned front,
                                                input int unsigned sync,
                                                input int unsigned back);
      axis_bounds_t b;
      b.total      = visible + front + sync + back;
      b.sync_first = visible + front;
      b.sync_last  = visible + front + sync - 1;
      return b;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: enable-gated wrap counter with visible/sync window decode.
// Flags are combinational from the count register; o_wrap marks the terminal count.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int VISIBLE = 800,
   parameter int FRONT   = 40,
   parameter int SYNC    = 128,
   parameter int BACK    = 88,
   parameter int CNT_W   = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_count,
   output logic             o_visible,
   output logic             o_sync_active,
   output logic             o_wrap
);

   localparam axis_bounds_t B = axis_bounds(VISIBLE, FRONT, SYNC, BACK);
   localparam logic [CNT_W-1:0] LAST       = CNT_W'(B.total - 1);
   localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(B.sync_first);
   localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(B.sync_last);
   localparam logic [CNT_W-1:0] VIS_END    = CNT_W'(VISIBLE);

   generate
      if (longint'(B.total) > (longint'(1) << CNT_W)) begin : g_total_too_big
         $error("vga_axis_counter: axis total does not fit in CNT_W bits");
      end
      if (SYNC < 1) begin : g_sync_zero
         $error("vga_axis_counter: sync width must be at least 1");
      end
   endgenerate

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
      end
   end

   assign o_count       = r_count;
   assign o_visible     = (r_count < VIS_END);
   assign o_sync_active = (r_count >= SYNC_FIRST) && (r_count <= SYNC_LAST);
   assign o_wrap        = (r_count == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: clk divider -> request-side x/y -> PIPE_LAT-strobe
// alignment of sync/de so they leave the output registers together with rgb_in.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE  = VGA800_H_VISIBLE,
   parameter int H_FRONT    = VGA800_H_FRONT,
   parameter int H_SYNC     = VGA800_H_SYNC,
   parameter int H_BACK     = VGA800_H_BACK,
   parameter int V_VISIBLE  = VGA800_V_VISIBLE,
   parameter int V_FRONT    = VGA800_V_FRONT,
   parameter int V_SYNC     = VGA800_V_SYNC,
   parameter int V_BACK     = VGA800_V_BACK,
   parameter bit H_SYNC_POS = VGA800_SYNC_POS,
   parameter bit V_SYNC_POS = VGA800_SYNC_POS,
   parameter int CLK_DIV    = 6,
   parameter int PIPE_LAT   = 2,
   parameter int CNT_W      = 11,
   parameter int COLOR_W    = VGA_COLOR_W
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 pix_stb,
   output logic [CNT_W-1:0]     req_x,
   output logic [CNT_W-1:0]     req_y,
   output logic                 req_de,
   output logic                 line_start,
   output logic                 frame_start,
   input  logic [3*COLOR_W-1:0] rgb_in,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 de,
   output logic [COLOR_W-1:0]   red,
   output logic [COLOR_W-1:0]   green,
   output logic [COLOR_W-1:0]   blue
);

   generate
      if (CLK_DIV < 1 || PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_bad_cfg
         $error("vga_timing_gen: CLK_DIV must be >= 1 and PIPE_LAT in 0..7");
      end
   endgenerate

   localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);

   logic [TICK_W-1:0] r_tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick <= '0;
      end else begin
         r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;
      end
   end

   // Tick resets to 0, so the first strobe lands in the first cycle after reset.
   assign pix_stb = (r_tick == '0);

   logic w_h_vis, w_h_sync, w_h_wrap;
   logic w_v_vis, w_v_sync, w_v_wrap_unused;

   vga_axis_counter #(
      .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CNT_W(CNT_W)
   ) u_h_cnt (
      .clk(clk), .rst(rst), .i_en(pix_stb),
      .o_count(req_x), .o_visible(w_h_vis), .o_sync_active(w_h_sync), .o_wrap(w_h_wrap)
   );

   vga_axis_counter #(
      .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CNT_W(CNT_W)
   ) u_v_cnt (
      .clk(clk), .rst(rst), .i_en(pix_stb && w_h_wrap),
      .o_count(req_y), .o_visible(w_v_vis), .o_sync_active(w_v_sync), .o_wrap(w_v_wrap_unused)
   );

   raster_ctl_t w_raw, w_dly;

   assign w_raw.hs    = w_h_sync;
   assign w_raw.vs    = w_v_sync;
   assign w_raw.de    = w_h_vis && w_v_vis;
   assign req_de      = w_raw.de;
   assign line_start  = pix_stb && !rst && (req_x == '0);
   assign frame_start = line_start && (req_y == '0);

   generate
      if (PIPE_LAT == 0) begin : g_no_pipe
         assign w_dly = w_raw;
      end else begin : g_pipe
         raster_ctl_t r_pipe [PIPE_LAT];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < PIPE_LAT; i++) r_pipe[i] <= '0;
            end else if (pix_stb) begin
               r_pipe[0] <= w_raw;
               for (int i = 1; i < PIPE_LAT; i++) r_pipe[i] <= r_pipe[i-1];
            end
         end

         assign w_dly = r_pipe[PIPE_LAT-1];
      end
   endgenerate

   logic                 r_hsync, r_vsync, r_de;
   logic [3*COLOR_W-1:0] r_rgb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hsync <= ~H_SYNC_POS;
         r_vsync <= ~V_SYNC_POS;
         r_de    <= 1'b0;
         r_rgb   <= '0;
      end else if (pix_stb) begin
         r_hsync <= w_dly.hs ? H_SYNC_POS : ~H_SYNC_POS;
         r_vsync <= w_dly.vs ? V_SYNC_POS : ~V_SYNC_POS;
         r_de    <= w_dly.de;
         r_rgb   <= w_dly.de ? rgb_in : '0;
      end
   end

   assign hsync = r_hsync;
   assign vsync = r_vsync;
   assign de    = r_de;
   assign {red, green, blue} = r_rgb;

endmodule
